// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready/data handshake bundle for one side of a pipeline stage.
interface pipe_stage_reg_if #(parameter int WIDTH = 32);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-beat pipeline register with stall counter and flush.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  pipe_stage_reg_if.slave    up,
  pipe_stage_reg_if.master   dn,
  output logic [CNT_W-1:0]   stall_cnt
);
  logic [WIDTH-1:0] main_q;
  assign dn.data = main_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (flush) stall_cnt <= '0;
    else if (dn.valid && !dn.ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t           state, nxt;
  logic [WIDTH-1:0] skid_q, main_d, skid_d;
  logic             rdy_q, push, pop;
  assign up.ready = rdy_q;
  assign dn.valid = state != EMPTY;
  assign push = up.valid && rdy_q;
  assign pop = dn.valid && dn.ready;
  always_comb begin
    nxt = state;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      nxt = EMPTY;
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else
      case (state)
        EMPTY: if (push) begin
          nxt = ONE;
          main_d = up.data;
        end
        ONE: if (push && pop) main_d = up.data;
        else if (push) begin
          nxt = TWO;
          skid_d = up.data;
        end else if (pop) begin
          nxt = EMPTY;
          main_d = BUBBLE;
        end
        TWO: if (pop) begin
          nxt = ONE;
          main_d = skid_q;
          skid_d = BUBBLE;
        end
        default: nxt = EMPTY;
      endcase
  end
  // in_ready stays low through reset and rises on the first edge after release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
      rdy_q <= 1'b0;
    end else begin
      state <= nxt;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q <= nxt != TWO;
    end
`else
  logic valid_q;
  assign dn.valid = valid_q;
  assign up.ready = !valid_q || dn.ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      main_q <= BUBBLE;
    end else if (flush) begin
      valid_q <= 1'b0;
      main_q <= BUBBLE;
    end else if (up.ready) begin
      valid_q <= up.valid;
      main_q <= up.valid ? up.data : BUBBLE;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue model.
module tb_pipe_stage_reg;
  localparam logic [7:0] BUB = 8'h5A;
  localparam int CMAX = 7;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [2:0] stall_cnt;
  pipe_stage_reg_if #(.WIDTH(8)) up ();
  pipe_stage_reg_if #(.WIDTH(8)) dn ();
  pipe_stage_reg #(.WIDTH(8), .BUBBLE(BUB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up), .dn(dn), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  logic [7:0] q[$];
  int cnt = 0;
  bit mrdy = 1'b0;
  function automatic bit exp_rdy();
    return (CAP == 2) ? mrdy : (q.size() == 0 || dn.ready);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    cnt = 0;
    mrdy = 1'b0;
  endtask
  task automatic cyc(input bit v, input logic [7:0] d, input bit ordy, input bit fl);
    bit acc, pop, stall;
    up.valid = v;
    up.data = d;
    dn.ready = ordy;
    flush = fl;
    #1;
    chk("in_ready", {31'b0, up.ready}, {31'b0, exp_rdy()});
    acc = v && exp_rdy();
    pop = q.size() > 0 && ordy;
    stall = q.size() > 0 && !ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
      cnt = 0;
    end else begin
      if (stall && cnt < CMAX) cnt++;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    mrdy = q.size() < CAP;
    #1;
    chk("out_valid", {31'b0, dn.valid}, {31'b0, q.size() > 0});
    chk("out_data", {24'b0, dn.data}, {24'b0, q.size() > 0 ? q[0] : BUB});
    chk("stall_cnt", {29'b0, stall_cnt}, cnt);
  endtask
  initial begin
    up.valid = 1'b0;
    up.data = '0;
    dn.ready = 1'b0;
    #12;
    chk("rst_valid", {31'b0, dn.valid}, 0);
    chk("rst_data", {24'b0, dn.data}, {24'b0, BUB});
    chk("rst_cnt", {29'b0, stall_cnt}, 0);
    chk("rst_in_ready", {31'b0, up.ready}, (CAP == 2) ? 0 : 1);
    model_reset();
    rst_n = 1'b1;
    cyc(0, 8'h00, 1, 0);
    // three back-to-back beats with downstream always ready
    cyc(1, 8'h11, 1, 0);
    chk("seq_0x11", {24'b0, dn.data}, 32'h11);
    cyc(1, 8'h22, 1, 0);
    chk("seq_0x22", {24'b0, dn.data}, 32'h22);
    cyc(1, 8'h33, 1, 0);
    chk("seq_0x33", {24'b0, dn.data}, 32'h33);
    cyc(0, 8'h00, 1, 0);
    chk("seq_empty", {31'b0, dn.valid}, 0);
    // fill and stall for five cycles
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'hB6, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 0);
    chk("stall_hold_data", {24'b0, dn.data}, 32'hA5);
    chk("stall_cnt5", {29'b0, stall_cnt}, 5);
    chk("full_in_ready", {31'b0, up.ready}, 0);
    cyc(0, 8'h00, 1, 0);
    chk("drain_second", {24'b0, dn.data}, (CAP == 2) ? 32'hB6 : {24'b0, BUB});
    cyc(0, 8'h00, 1, 0);
    chk("drain_done", {31'b0, dn.valid}, 0);
    // refill, stall to 7, then flush alongside a new beat
    cyc(1, 8'hA5, 0, 0);
    cyc(1, 8'hB6, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 0, 0);
    chk("pre_flush_cnt", {29'b0, stall_cnt}, 7);
    cyc(1, 8'hCC, 0, 1);
    chk("flush_valid", {31'b0, dn.valid}, 0);
    chk("flush_data", {24'b0, dn.data}, {24'b0, BUB});
    chk("flush_cnt", {29'b0, stall_cnt}, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 1, 1);
    // saturation with a single held beat
    cyc(1, 8'h3C, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 8'h00, 0, 0);
    chk("sat_cnt", {29'b0, stall_cnt}, 7);
    cyc(0, 8'h00, 1, 0);
    // asynchronous reset between edges while holding a beat
    cyc(1, 8'h77, 0, 0);
    chk("pre_rst_valid", {31'b0, dn.valid}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, dn.valid}, 0);
    chk("arst_data", {24'b0, dn.data}, {24'b0, BUB});
    chk("arst_cnt", {29'b0, stall_cnt}, 0);
    model_reset();
    #1;
    rst_n = 1'b1;
    cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter BUBBLE, default 0 (WIDTH bits), value driven on out_data when the stage holds no valid beat.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 flush  input  1  synchronous discard of all held beats.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts a beat.
REQ-012 out_data  output  WIDTH  downstream payload.
REQ-013 stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
REQ-014 Transfer in occurs when in_valid && in_ready at a rising edge; transfer out occurs when out_valid && out_ready.
REQ-015 Beats leave in arrival order; none is duplicated or dropped except by flush.
REQ-016 Latency: a beat accepted at edge N is presented on out_data/out_valid after edge N (1 cycle).
REQ-017 While out_valid && !out_ready, out_data and out_valid stay stable.
REQ-018 While out_valid=0, out_data equals BUBBLE.
REQ-019 Simultaneous transfer in and transfer out in one cycle keeps the stage full with the new beat; throughput is 1 beat/cycle with out_ready held high.
REQ-020 flush=1 at an edge clears all held beats: out_valid=0, out_data=BUBBLE after the edge; a beat accepted at that same edge is discarded; flush overrides transfer in.
REQ-021 Flush with no held beats is harmless; in_ready follows REQ-023/REQ-025 during flush.
REQ-022 stall_cnt increments each edge where out_valid && !out_ready, saturates at 2^CNT_W-1 and never wraps; flush clears it to 0.

Reset
REQ-023 While rst_n=0: out_valid=0, out_data=BUBBLE, stall_cnt=0, skid storage empty; in_ready=1 after reset release (combinational variant), in_ready=0 during reset and 1 from the first edge after release (skid variant).
REQ-024 Reset assertion mid-transfer discards all held beats immediately, without waiting for a clock edge.

Configuration
REQ-025 Macro PIPE_STAGE_SKID_EN defined: two-entry skid buffer with states EMPTY, ONE (main only), TWO (main+skid); in_ready is a register output = state!=TWO; EMPTY->ONE on in; ONE->TWO on in && !out; TWO->ONE on out (skid moves to main); ONE->EMPTY on out && !in; flush -> EMPTY from any state.
REQ-026 Macro undefined: single register, in_ready = !out_valid || out_ready (combinational path from out_ready); skid storage absent; all other requirements identical.

Verification
REQ-027 Reset then in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, out_valid high 3 cycles, stall_cnt=0.
REQ-028 Fill with 0xA5, out_ready=0 for 5 cycles -> out_data stable 0xA5, stall_cnt=5; skid build: in_ready drops after second beat 0xB6 accepted; no-skid build: in_ready=0 after first beat.
REQ-029 Skid build in TWO (0xA5, 0xB6), raise out_ready -> 0xA5 then 0xB6 on consecutive cycles, in_ready returns to 1 one edge after first transfer out.
REQ-030 Hold in TWO/full with stall_cnt=7, assert flush same cycle as in_valid with 0xCC -> out_valid=0, out_data=BUBBLE, stall_cnt=0, 0xCC never appears.
REQ-031 CNT_W=3, out_ready=0 for 10 cycles with a held beat -> stall_cnt saturates at 7.
REQ-032 Assert rst_n=0 between edges while full -> out_valid=0 and out_data=BUBBLE immediately, before the next edge.
